// File: rtl/data_sync_arbiter_if.sv
// Handshake bundle between N requesters and the arbiter. The arbiter uses the
// slave side and drives the DATA_SYNC inputs (unsync_bus/bus_enable).
interface data_sync_arbiter_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant;
  logic [W-1:0]   unsync_bus;
  logic           bus_enable;
  logic [IDW-1:0] src_id;
  logic           busy;

  modport master (
    output req, req_data,
    input  grant, unsync_bus, bus_enable, src_id, busy
  );

  modport slave (
    input  req, req_data,
    output grant, unsync_bus, bus_enable, src_id, busy
  );
endinterface

// File: rtl/data_sync_arbiter.sv
// Round-robin arbiter sharing one DATA_SYNC crossing: holds bus_enable high for
// HOLD_CYCLES, low for GAP_CYCLES, and keeps the data stable between grants.
module data_sync_arbiter #(
  parameter int W           = 8,
  parameter int N           = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  data_sync_arbiter_if.slave      bus
);
  localparam int IDW  = $clog2(N);
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [N-1:0]   grant_r, grant_s;
  logic [W-1:0]   data_r, data_s;
  logic           en_r, en_s;
  logic [IDW-1:0] id_r, id_s;
  logic [IDW-1:0] last_r, last_s;
  logic           busy_r;
  logic           found_s;
  logic [IDW-1:0] win_s;

  // Round-robin pick: first requester at or after last+1, wrapping.
  always_comb begin
    found_s = 1'b0;
    win_s   = {IDW{1'b0}};
    for (int i = 1; i <= N; i++) begin
      if (!found_s && bus.req[(int'(last_r) + i) % N]) begin
        found_s = 1'b1;
        win_s   = IDW'((int'(last_r) + i) % N);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and next-output logic; data/id/last hold unless a grant occurs.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    grant_s = {N{1'b0}};
    data_s  = data_r;
    en_s    = en_r;
    id_s    = id_r;
    last_s  = last_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          data_s         = bus.req_data[int'(win_s)*W +: W];
          id_s           = win_s;
          en_s           = 1'b1;
          grant_s[win_s] = 1'b1;
          last_s         = win_s;
          cnt_s          = CW'(HOLD_CYCLES - 1);
          state_s        = HOLD;
        end else begin
          state_s = IDLE;
        end
      end
      HOLD: begin
        if (cnt_r != {CW{1'b0}}) begin
          cnt_s = cnt_r - CW'(1);
        end else begin
          en_s    = 1'b0;
          cnt_s   = CW'(GAP_CYCLES - 1);
          state_s = GAP;
        end
      end
      GAP: begin
        if (cnt_r != {CW{1'b0}}) begin
          cnt_s = cnt_r - CW'(1);
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        en_s    = 1'b0;
        cnt_s   = {CW{1'b0}};
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops bus_enable immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      grant_r <= {N{1'b0}};
      data_r  <= {W{1'b0}};
      en_r    <= 1'b0;
      id_r    <= {IDW{1'b0}};
      last_r  <= IDW'(N - 1);
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      grant_r <= grant_s;
      data_r  <= data_s;
      en_r    <= en_s;
      id_r    <= id_s;
      last_r  <= last_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  assign bus.grant      = grant_r;
  assign bus.unsync_bus = data_r;
  assign bus.bus_enable = en_r;
  assign bus.src_id     = id_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_data_sync_arbiter.sv
// Directed bench for data_sync_arbiter with hand-computed grant order,
// hold/gap timing and data stability expectations.
module tb_data_sync_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  data_sync_arbiter_if #(.W(W), .N(N)) bus ();

  data_sync_arbiter #(.W(W), .N(N), .HOLD_CYCLES(4), .GAP_CYCLES(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Requester data: d3=D3, d2=C2, d1=A5, d0=90
  localparam logic [N*W-1:0] DATA = 32'hD3C2A590;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_grant(input int budget, output int cycles, output logic [N-1:0] g);
    cycles = -1;
    g      = 4'b0000;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (bus.grant !== 4'b0000) begin
        cycles = i;
        g      = bus.grant;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    RST     = 1'b0;
    bus.req = 4'b0000;
    step();
    step();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    bus.req      = 4'b0000;
    bus.req_data = DATA;
    RST          = 1'b0;
    #3;
    tests_run++;
    if (bus.grant !== 4'b0000 || bus.unsync_bus !== 8'h00 || bus.src_id !== 2'd0 ||
        bus.bus_enable !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: grant=%b bus=%h id=%0d en=%b busy=%b required all zero",
               bus.grant, bus.unsync_bus, bus.src_id, bus.bus_enable, bus.busy);
    end
    step();
    RST = 1'b1;
    step();
    step();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin
      tests_failed++;
      $display("FAIL idle_no_req: busy=%b grant=%b required 0/0000", bus.busy, bus.grant);
    end
  endtask

  task automatic test_single();
    int cyc, hi, lo;
    logic [N-1:0] g;
    apply_reset();
    bus.req = 4'b0010;
    wait_grant(20, cyc, g);
    bus.req = 4'b0000;
    tests_run++;
    if (g !== 4'b0010 || cyc !== 1) begin
      tests_failed++;
      $display("FAIL single_grant: grant=%b after %0d cycles required 0010 after 1", g, cyc);
    end
    tests_run++;
    if (bus.unsync_bus !== 8'hA5 || bus.src_id !== 2'd1 || bus.bus_enable !== 1'b1 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_data: bus=%h id=%0d en=%b busy=%b required A5/1/1/1",
               bus.unsync_bus, bus.src_id, bus.bus_enable, bus.busy);
    end
    hi = 1;
    lo = 0;
    step();
    tests_run++;
    if (bus.grant !== 4'b0000) begin
      tests_failed++;
      $display("FAIL grant_one_cycle: grant=%b required 0000", bus.grant);
    end
    if (bus.bus_enable === 1'b1) hi++;
    for (int i = 0; i < 2; i++) begin
      step();
      if (bus.bus_enable === 1'b1) hi++;
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.bus_enable === 1'b0 && bus.busy === 1'b1) lo++;
    end
    tests_run++;
    if (hi !== 4 || lo !== 4) begin
      tests_failed++;
      $display("FAIL hold_gap: high=%0d low=%0d required 4/4", hi, lo);
    end
    step();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.unsync_bus !== 8'hA5 || bus.src_id !== 2'd1) begin
      tests_failed++;
      $display("FAIL idle_hold_data: busy=%b bus=%h id=%0d required 0/A5/1",
               bus.busy, bus.unsync_bus, bus.src_id);
    end
  endtask

  task automatic test_simultaneous();
    int cyc;
    logic [N-1:0] g;
    logic [N-1:0] exp_g [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    apply_reset();
    bus.req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_grant(20, cyc, g);
      tests_run++;
      if (g !== exp_g[k] || (k > 0 && cyc !== 9)) begin
        tests_failed++;
        $display("FAIL simul_grant%0d: grant=%b spacing=%0d required %b spacing 9",
                 k, g, cyc, exp_g[k]);
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_fairness();
    int cyc;
    logic [N-1:0] g;
    logic [1:0]   exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [W-1:0] exp_d  [5] = '{8'h90, 8'hA5, 8'hC2, 8'hD3, 8'h90};
    apply_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(20, cyc, g);
      tests_run++;
      if (g !== (4'b0001 << exp_id[k]) || bus.src_id !== exp_id[k] || bus.unsync_bus !== exp_d[k]) begin
        tests_failed++;
        $display("FAIL fair%0d: grant=%b id=%0d bus=%h required id %0d bus %h",
                 k, g, bus.src_id, bus.unsync_bus, exp_id[k], exp_d[k]);
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_req_during_hold();
    int cyc, bad;
    logic [N-1:0] g;
    apply_reset();
    bus.req = 4'b0010;
    wait_grant(20, cyc, g);
    bus.req = 4'b1000;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.grant !== 4'b0000 || bus.unsync_bus !== 8'hA5) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL hold_ignore_req: %0d bad cycles required 0", bad);
    end
    step();
    tests_run++;
    if (bus.grant !== 4'b1000 || bus.unsync_bus !== 8'hD3 || bus.src_id !== 2'd3) begin
      tests_failed++;
      $display("FAIL hold_then_grant: grant=%b bus=%h id=%0d required 1000/D3/3",
               bus.grant, bus.unsync_bus, bus.src_id);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_withdrawn();
    int cyc, g2, rises;
    logic [N-1:0] g;
    logic prev_en;
    apply_reset();
    bus.req = 4'b0001;
    wait_grant(20, cyc, g);
    bus.req = 4'b0000;
    for (int i = 0; i < 4; i++) step();
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    g2      = 0;
    rises   = 0;
    prev_en = bus.bus_enable;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus.grant[2] === 1'b1) g2++;
      if (bus.bus_enable === 1'b1 && prev_en === 1'b0) rises++;
      prev_en = bus.bus_enable;
    end
    tests_run++;
    if (g2 !== 0 || rises !== 0) begin
      tests_failed++;
      $display("FAIL withdrawn: grant2=%0d extra_enables=%0d required 0/0", g2, rises);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [N-1:0] g;
    apply_reset();
    bus.req = 4'b0001;
    wait_grant(20, cyc, g);
    bus.req = 4'b0000;
    step();
    RST = 1'b0;
    #1;
    tests_run++;
    if (bus.bus_enable !== 1'b0 || bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.unsync_bus !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid: en=%b grant=%b busy=%b bus=%h required 0/0000/0/00",
               bus.bus_enable, bus.grant, bus.busy, bus.unsync_bus);
    end
    step();
    RST     = 1'b1;
    bus.req = 4'b1000;
    wait_grant(20, cyc, g);
    tests_run++;
    if (g !== 4'b1000 || cyc !== 1 || bus.unsync_bus !== 8'hD3) begin
      tests_failed++;
      $display("FAIL reset_regrant: grant=%b after %0d bus=%h required 1000 after 1, D3",
               g, cyc, bus.unsync_bus);
    end
    bus.req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_req_during_hold();
    test_withdrawn();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
